// File: rtl/instrument_uart_tx.sv
// instrument_uart_tx: 8N1 serial transmitter for the instrument link.
// Sends a packet SYNC(0x80), BASS, DRUM on TxD; data bytes have MSB
// forced to 0 so the receiver can find the sync byte.
// Build option: define INSTR_TX_CHECKSUM_EN to append a CHK byte
// (bass ^ drum, MSB 0) after DRUM, making the packet four bytes long.
module instrument_uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] bass,
  input  logic [7:0] drum,
  output logic       busy,
  output logic       TxD
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [7:0]    SYNC    = 8'h80;
`ifdef INSTR_TX_CHECKSUM_EN
  localparam logic [1:0]    LAST_IDX = 2'd3;
`else
  localparam logic [1:0]    LAST_IDX = 2'd2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [1:0]      byte_idx, byte_n;
  logic [7:0]      shift, shift_n;
  logic [6:0]      bass_q, drum_q;
  logic            txd_q, txd_n;
  logic            capture;
  logic            wrap;

  // Only the low seven operand bits are ever transmitted.
  logic            unused_msb;
  assign unused_msb = bass[7] ^ drum[7];

  // Packet byte for a given position, built from the captured operands.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [6:0] b,
                                            input logic [6:0] d);
    logic [7:0] r;
    case (idx)
      2'd0:    r = SYNC;
      2'd1:    r = {1'b0, b};
      2'd2:    r = {1'b0, d};
`ifdef INSTR_TX_CHECKSUM_EN
      default: r = {1'b0, b ^ d};
`else
      default: r = SYNC;
`endif
    endcase
    return r;
  endfunction

  assign wrap    = (cnt == CNT_MAX);
  assign capture = (state == IDLE) && send;

  // Next-state, baud/bit/byte counters and next serial bit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shift_n = shift;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (send) begin
          shift_n = SYNC;
          byte_n  = 2'd0;
          bit_n   = 3'd0;
          state_n = START;
        end
      end
      START: begin
        if (wrap) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          cnt_n = '0;
          if (byte_idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            byte_n  = byte_idx + 2'd1;
            shift_n = frame_byte(byte_idx + 2'd1, bass_q, drum_q);
            state_n = START;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // State, counters, shift register, output bit and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shift    <= 8'd0;
      txd_q    <= 1'b1;
      bass_q   <= 7'd0;
      drum_q   <= 7'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      shift    <= shift_n;
      txd_q    <= txd_n;
      if (capture) begin
        bass_q <= bass[6:0];
        drum_q <= drum[6:0];
      end
    end
  end

  assign TxD  = txd_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_instrument_uart_tx.sv
// Scoreboard bench for instrument_uart_tx: stimulus pushes expected frames
// and busy durations; independent monitors decode the line and busy.
module tb_instrument_uart_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef INSTR_TX_CHECKSUM_EN
  localparam int P = 4;
`else
  localparam int P = 3;
`endif
  localparam int FRAME   = 10 * DIV;
  localparam int PKT_LEN = P * FRAME;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] bass = 8'd0;
  logic [7:0] drum = 8'd0;
  logic       busy;
  logic       TxD;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] value;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   busy_q[$];
  int   busy_end = 0;
  int   last_start = 0;

  instrument_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk  (clk),
    .rst  (rst),
    .send (send),
    .bass (bass),
    .drum (drum),
    .busy (busy),
    .TxD  (TxD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h) cycle=%0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_byte(input int k, input logic [7:0] b,
                                            input logic [7:0] d);
    case (k)
      0:       return 8'h80;
      1:       return b & 8'h7F;
      2:       return d & 8'h7F;
      default: return (b ^ d) & 8'h7F;
    endcase
  endfunction

  // Called just after a rising edge; drives send for one cycle.
  task automatic issue(input logic [7:0] b, input logic [7:0] d,
                       input logic with_rst);
    int   e;
    exp_t x;
    send = 1'b1;
    bass = b;
    drum = d;
    rst  = with_rst;
    e = cyc + 1;
    if (with_rst) begin
      busy_end = e;
    end else if (e > busy_end) begin
      for (int k = 0; k < P; k++) begin
        x.value = model_byte(k, b, d);
        x.start = e + k * FRAME;
        exp_q.push_back(x);
      end
      busy_q.push_back(PKT_LEN);
      busy_end   = e + PKT_LEN;
      last_start = e;
    end
    @(posedge clk); #1;
    send = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 4 * PKT_LEN) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_idle_timeout", busy, 0);
  endtask

  // Line monitor: decodes each 8N1 frame and checks it against the queue.
  initial begin
    logic       prev;
    logic       v;
    logic       first;
    logic       ok;
    logic       aborted;
    logic [9:0] bitv;
    int         s;
    exp_t       x;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !TxD) begin
        s       = cyc;
        aborted = 1'b0;
        ok      = 1'b1;
        bitv    = '0;
        first   = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int j = 0; j < DIV && !aborted; j++) begin
            if (!(b == 0 && j == 0)) begin
              @(negedge clk);
              if (rst) aborted = 1'b1;
            end
            if (!aborted) begin
              v = TxD;
              if (j == 0) first = v;
              else if (v !== first) ok = 1'b0;
            end
          end
          if (!aborted) bitv[b] = first;
        end
        if (aborted) begin
          prev = TxD;
        end else begin
          check("bit_stable", ok, 1);
          check("stop_bit", bitv[9], 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: actual=0x%0h expected=none start=%0d",
                     bitv[8:1], s);
          end else begin
            x = exp_q.pop_front();
            check("byte_value", bitv[8:1], x.value);
            check("byte_start_cycle", s, x.start);
          end
          prev = 1'b1;
        end
      end else begin
        prev = TxD;
      end
    end
  end

  // Busy monitor: measures each busy pulse against the expected length.
  initial begin
    logic pb;
    int   rise;
    int   e;
    pb   = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && !pb) rise = cyc;
      if (busy === 1'b0 && pb) begin
        if (busy_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_busy: actual=%0d expected=none", cyc - rise);
        end else begin
          e = busy_q.pop_front();
          check("busy_length", cyc - rise, e);
        end
      end
      pb = (busy === 1'b1);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] d;
    int         rs;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_txd", TxD, 1);
    check("reset_busy", busy, 0);

    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("idle_line", {TxD, busy}, 2'b10);
    end

    issue(8'h25, 8'h5A, 1'b0);
    wait_idle();
    idle(4);

    issue(8'hFF, 8'h80, 1'b0);
    wait_idle();
    idle(4);

    // Operand change and dropped send while a packet is in flight.
    issue(8'h11, 8'h22, 1'b0);
    idle(10);
    bass = 8'h7E;
    drum = 8'h01;
    while (cyc + 1 < last_start + 50) begin
      @(posedge clk); #1;
    end
    issue(8'h55, 8'h66, 1'b0);
    wait_idle();
    idle(PKT_LEN / 2);

    // Reset in the middle of the DRUM byte, then a clean packet.
    issue(8'h33, 8'h4C, 1'b0);
    rs = last_start + 2 * FRAME + FRAME / 2;
    while (cyc + 1 < rs) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_q.delete();
    busy_q[busy_q.size() - 1] = rs - last_start;
    busy_end = rs;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_txd", TxD, 1);
    check("rst_mid_busy", busy, 0);
    issue(8'h0F, 8'h70, 1'b0);
    wait_idle();

    // Back-to-back: send on the first cycle busy is low.
    issue(8'h6A, 8'h15, 1'b0);
    wait_idle();
    issue(8'h01, 8'h7F, 1'b0);
    wait_idle();
    idle(3);

    // send together with rst: reset wins.
    issue(8'h12, 8'h34, 1'b1);
    check("send_rst_busy", busy, 0);
    check("send_rst_txd", TxD, 1);
    idle(2 * FRAME);

    // Randomized packets with random mid-packet send attempts.
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      d = 8'($urandom);
      issue(b, d, 1'b0);
      idle($urandom_range(0, PKT_LEN + 200));
      b = 8'($urandom);
      d = 8'($urandom);
      issue(b, d, 1'b0);
      wait_idle();
      idle($urandom_range(0, 3));
    end

    idle(FRAME);
    check("exp_queue_empty", exp_q.size(), 0);
    check("busy_queue_empty", busy_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
